// File: rtl/store_merge.sv
// store_merge: turns sw/sb/sh store requests into full-word writes, using read-modify-write for sub-word stores.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   req_valid_i  M stage holds a store this cycle
//   op_i         00 sw, 01 sb, 10 sh, 11 no store
//   addr_i       byte address of the store
//   wdata_i      store data (sb uses [7:0], sh uses [15:0])
//   flush_i      aborts a pending sequence (ignored in the write cycle)
//   busy_o       pipeline stall request
//   ades_o       misaligned-store flag
//   done_o       pulses in the write cycle
//   mem_addr_o   word address of the access
//   mem_re_o     read strobe, data returns next cycle on mem_rdata_i
//   mem_rdata_i  read data
//   mem_we_o     full-word write strobe
//   mem_wdata_o  merged write word
module store_merge (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        ades_o,
    output logic        done_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_re_o,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_e;
    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SB = 2'b01;
    localparam logic [1:0] OP_SH = 2'b10;
    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic [31:0] buf_q;
    logic        misaligned, is_idle, accept;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data, merged;
    assign misaligned = (op_i == OP_SW && addr_i[1:0] != 2'b00) || (op_i == OP_SH && addr_i[0]);
    assign is_idle    = state_q == IDLE;
    assign accept     = is_idle && req_valid_i && op_i != 2'b11 && !misaligned && !flush_i;
    // Sub-word data is replicated across the word; the mask picks which lanes replace the RAM bytes.
    always_comb begin
        lane_mask = op_q == OP_SB ? 4'b0001 << addr_q[1:0] : (addr_q[1] ? 4'b1100 : 4'b0011);
        lane_data = op_q == OP_SB ? {4{wdata_q[7:0]}} : {2{wdata_q}};
        merged    = mem_rdata_i;
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = lane_mask[k] ? lane_data[8*k +: 8] : mem_rdata_i[8*k +: 8];
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= op_i;
                    addr_q  <= addr_i;
                    wdata_q <= wdata_i[15:0];
                    if (op_i == OP_SW) begin
                        buf_q   <= wdata_i;
                        state_q <= WRITE;
                    end else begin
                        state_q <= READ;
                    end
                end
                READ: state_q <= flush_i ? IDLE : WAIT;
                WAIT: if (flush_i) begin
                    state_q <= IDLE;
                end else begin
                    buf_q   <= merged;
                    state_q <= WRITE;
                end
                WRITE: state_q <= IDLE;
            endcase
        end
    end
    // A flush in READ/WAIT releases the stall in the same cycle.
    assign busy_o      = accept || ((state_q == READ || state_q == WAIT) && !flush_i);
    assign ades_o      = is_idle && req_valid_i && !flush_i && misaligned;
    assign mem_re_o    = state_q == READ;
    assign mem_we_o    = state_q == WRITE;
    assign done_o      = state_q == WRITE;
    assign mem_wdata_o = state_q == WRITE ? buf_q : '0;
    assign mem_addr_o  = is_idle ? '0 : {addr_q[31:2], 2'b00};
endmodule

// File: tb/tb_store_merge.sv
// tb_store_merge: directed stimulus with a write scoreboard for store_merge.
module tb_store_merge;
    logic        clk = 0;
    logic        reset = 1;
    logic        req_valid = 0;
    logic [1:0]  op = 0;
    logic [31:0] addr = 0;
    logic [31:0] wdata = 0;
    logic        flush = 0;
    logic        busy, ades, done, mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    int          passed = 0;
    int          total = 0;
    int          writes = 0;
    logic [63:0] exp_q[$];

    store_merge dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .op_i(op),
        .addr_i(addr), .wdata_i(wdata), .flush_i(flush), .busy_o(busy),
        .ades_o(ades), .done_o(done), .mem_addr_o(mem_addr), .mem_re_o(mem_re),
        .mem_rdata_i(mem_rdata), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Check the per-cycle control outputs mid-cycle, then advance to just after the next edge.
    task automatic cyc(input logic e_busy, input logic e_ades, input logic e_re, input logic e_we);
        @(negedge clk);
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("ades", {31'b0, ades}, {31'b0, e_ades});
        chk("mem_re", {31'b0, mem_re}, {31'b0, e_re});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        chk("done", {31'b0, done}, {31'b0, e_we});
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1;
        op = o;
        addr = a;
        wdata = d;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic subword(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_word);
        req(o, a, d);
        expect_wr({a[31:2], 2'b00}, exp_word);
        cyc(1, 0, 0, 0);
        req_valid = 0;
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            logic [63:0] e;
            writes++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e[63:32]);
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_strobes", {29'b0, mem_re, mem_we, done}, 0);
        @(posedge clk);
        #1;
        reset = 0;
        cyc(0, 0, 0, 0);
        // sw: one stall cycle then the write.
        req(2'b00, 32'h1004, 32'hDEADBEEF);
        expect_wr(32'h1004, 32'hDEADBEEF);
        cyc(1, 0, 0, 0);
        req_valid = 0;
        cyc(0, 0, 0, 1);
        // Sub-word stores over RAM word 0x11223344.
        mem_rdata = 32'h11223344;
        subword(2'b01, 32'h2002, 32'h000000AB, 32'h11AB3344);
        subword(2'b10, 32'h2002, 32'h0000CAFE, 32'hCAFE3344);
        subword(2'b10, 32'h2000, 32'h0000CAFE, 32'h1122CAFE);
        subword(2'b01, 32'h2003, 32'hFFFFFF55, 32'h55223344);
        // Misaligned and reserved ops.
        req(2'b10, 32'h2001, 32'h1234);
        cyc(0, 1, 0, 0);
        req(2'b00, 32'h2002, 32'h1234);
        cyc(0, 1, 0, 0);
        req(2'b11, 32'h2000, 32'h1234);
        cyc(0, 0, 0, 0);
        req_valid = 0;
        cyc(0, 0, 0, 0);
        // Flush in WAIT aborts the sb.
        req(2'b01, 32'h2001, 32'h99);
        cyc(1, 0, 0, 0);
        req_valid = 0;
        cyc(1, 0, 1, 0);
        flush = 1;
        cyc(0, 0, 0, 0);
        flush = 0;
        cyc(0, 0, 0, 0);
        // Flush in the accept cycle suppresses the accept.
        req(2'b01, 32'h2001, 32'h99);
        flush = 1;
        cyc(0, 0, 0, 0);
        flush = 0;
        req_valid = 0;
        cyc(0, 0, 0, 0);
        // Reset while in READ.
        req(2'b01, 32'h2001, 32'h99);
        cyc(1, 0, 0, 0);
        req_valid = 0;
        reset = 1;
        cyc(1, 0, 1, 0);
        reset = 0;
        @(negedge clk);
        chk("rr_mem_addr", mem_addr, 0);
        chk("rr_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0);
        // Back-to-back: sw held through its WRITE, then sb presented right after.
        req(2'b00, 32'h3000, 32'hA5A5A5A5);
        expect_wr(32'h3000, 32'hA5A5A5A5);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        req(2'b01, 32'h3001, 32'h00000077);
        expect_wr(32'h3000, 32'h11227744);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        req_valid = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("pending_writes", exp_q.size(), 0);
        chk("write_count", writes, 7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
